// File: rtl/core_result_gather.sv
// ---------------------------------------------------------------------------
// core_result_gather
//   Collects one pair of result words from each of NUM_CORES child cores,
//   exposes them through a registered read port and, on request, runs a
//   sequential minimum search over the captured val_1 words.
//
// Ports
//   i_clk, i_rst_n    : clock, synchronous active-low reset
//   i_core_flag       : per-core done flag (bit i = core i)
//   i_core_val_1/2    : flattened result words, core i at [i*DATA_W +: DATA_W]
//   i_clear           : synchronous soft clear, re-arms capture
//   i_rd_addr         : core index to read
//   o_rd_val_1/2      : captured words of core i_rd_addr (1-cycle latency)
//   o_rd_valid        : addressed core has a capture (1-cycle latency)
//   o_all_done        : every core has a capture
//   i_start_reduce    : single-cycle request to start the min search
//   o_reduce_busy     : search in progress
//   o_reduce_done     : search finished, o_best_* valid
//   o_best_val_1/2    : minimum val_1 and the matching val_2
//   o_best_core       : index of the winning core (lowest index on ties)
// ---------------------------------------------------------------------------

// Per-core sticky capture slot: first flag wins until reset/clear.
module core_capture_lane #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_flag,
    input  logic [DATA_W-1:0] i_val_1,
    input  logic [DATA_W-1:0] i_val_2,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_val_1,
    output logic [DATA_W-1:0] o_val_2
);
    logic              r_valid;
    logic [DATA_W-1:0] r_val_1;
    logic [DATA_W-1:0] r_val_2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_valid <= 1'b0;
            r_val_1 <= '0;
            r_val_2 <= '0;
        end else if (i_flag && !r_valid) begin
            r_valid <= 1'b1;
            r_val_1 <= i_val_1;
            r_val_2 <= i_val_2;
        end
    end

    assign o_valid = r_valid;
    assign o_val_1 = r_val_1;
    assign o_val_2 = r_val_2;
endmodule

module core_result_gather #(
    parameter int NUM_CORES = 31,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_CORES-1:0]        i_core_flag,
    input  logic [NUM_CORES*DATA_W-1:0] i_core_val_1,
    input  logic [NUM_CORES*DATA_W-1:0] i_core_val_2,
    input  logic                        i_clear,
    input  logic [ADDR_W-1:0]           i_rd_addr,
    output logic [DATA_W-1:0]           o_rd_val_1,
    output logic [DATA_W-1:0]           o_rd_val_2,
    output logic                        o_rd_valid,
    output logic                        o_all_done,
    input  logic                        i_start_reduce,
    output logic                        o_reduce_busy,
    output logic                        o_reduce_done,
    output logic [DATA_W-1:0]           o_best_val_1,
    output logic [DATA_W-1:0]           o_best_val_2,
    output logic [ADDR_W-1:0]           o_best_core
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    logic [NUM_CORES-1:0]             w_valid;
    logic [NUM_CORES-1:0][DATA_W-1:0] w_cap_1;
    logic [NUM_CORES-1:0][DATA_W-1:0] w_cap_2;

    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_lane
            core_capture_lane #(.DATA_W(DATA_W)) u_lane (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_clear (i_clear),
                .i_flag  (i_core_flag[g]),
                .i_val_1 (i_core_val_1[g*DATA_W +: DATA_W]),
                .i_val_2 (i_core_val_2[g*DATA_W +: DATA_W]),
                .o_valid (w_valid[g]),
                .o_val_1 (w_cap_1[g]),
                .o_val_2 (w_cap_2[g])
            );
        end
    endgenerate

    assign o_all_done = &w_valid;

    // Read mux: an address with no matching core (>= NUM_CORES) falls
    // through to the all-zero default.
    logic [DATA_W-1:0] w_rd_val_1;
    logic [DATA_W-1:0] w_rd_val_2;
    logic              w_rd_valid;

    always_comb begin
        w_rd_val_1 = '0;
        w_rd_val_2 = '0;
        w_rd_valid = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (i_rd_addr == ADDR_W'(i)) begin
                w_rd_val_1 = w_cap_1[i];
                w_rd_val_2 = w_cap_2[i];
                w_rd_valid = w_valid[i];
            end
        end
    end

    logic [DATA_W-1:0] r_rd_val_1;
    logic [DATA_W-1:0] r_rd_val_2;
    logic              r_rd_valid;

    // Soft clear does not touch the read registers; they keep tracking rd_addr.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_val_1 <= '0;
            r_rd_val_2 <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_val_1 <= w_rd_val_1;
            r_rd_val_2 <= w_rd_val_2;
            r_rd_valid <= w_rd_valid;
        end
    end

    assign o_rd_val_1 = r_rd_val_1;
    assign o_rd_val_2 = r_rd_val_2;
    assign o_rd_valid = r_rd_valid;

    // Entry under inspection during SCAN.
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] w_scan_val_1;
    logic [DATA_W-1:0] w_scan_val_2;

    always_comb begin
        w_scan_val_1 = '0;
        w_scan_val_2 = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_idx == ADDR_W'(i)) begin
                w_scan_val_1 = w_cap_1[i];
                w_scan_val_2 = w_cap_2[i];
            end
        end
    end

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_best_val_1;
    logic [DATA_W-1:0] r_best_val_2;
    logic [ADDR_W-1:0] r_best_core;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_best_val_1 <= '0;
            r_best_val_2 <= '0;
            r_best_core  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a fresh start as a rescan.
                    if (i_start_reduce && o_all_done) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (r_idx == '0 || w_scan_val_1 < r_best_val_1) begin
                        r_best_val_1 <= w_scan_val_1;
                        r_best_val_2 <= w_scan_val_2;
                        r_best_core  <= r_idx;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_reduce_busy = r_busy;
    assign o_reduce_done = r_done;
    assign o_best_val_1  = r_best_val_1;
    assign o_best_val_2  = r_best_val_2;
    assign o_best_core   = r_best_core;
endmodule

// File: doc/core_result_gather.md
Name: core_result_gather

Overview:
- Parametrised collector between NUM_CORES child processors and the parent core.
- Each child raises a done flag with two result words. The block latches each child's results once (sticky) and reports when all children are done.
- The parent reads any child's captured results through a registered read port.
- On request, the block runs a sequential minimum search over all captured val_1 words. It returns the winning val_1, its val_2 and the core index, so the parent no longer scans the cores in software.

Parameters:
- NUM_CORES, 31, number of child cores (2..2^ADDR_W).
- DATA_W, 32, width of each result word.
- ADDR_W, 5, width of core index and read address; 2^ADDR_W >= NUM_CORES.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-low reset.
- core_flag  in  NUM_CORES  per-core done flag; bit i belongs to core i.
- core_val_1  in  NUM_CORES*DATA_W  flattened val_1 words; core i at [i*DATA_W +: DATA_W].
- core_val_2  in  NUM_CORES*DATA_W  flattened val_2 words, same packing.
- clear  in  1  synchronous soft clear that re-arms capture.
- rd_addr  in  ADDR_W  core index to read.
- rd_val_1  out  DATA_W  captured val_1 of core rd_addr (registered).
- rd_val_2  out  DATA_W  captured val_2 of core rd_addr (registered).
- rd_valid  out  1  the addressed core has a capture (registered).
- all_done  out  1  every core has a capture.
- start_reduce  in  1  single-cycle request to start the min search.
- reduce_busy  out  1  FSM in SCAN.
- reduce_done  out  1  FSM in DONE; result outputs valid.
- best_val_1  out  DATA_W  minimum captured val_1.
- best_val_2  out  DATA_W  val_2 of the winning core.
- best_core  out  ADDR_W  index of the winning core.

Behaviour:
- Reset (Reset=0 at an edge) clears the following to 0:
  - all capture valid bits v[] and capture registers;
  - rd_val_1, rd_val_2, rd_valid;
  - best_val_1, best_val_2, best_core;
  - the scan index. The FSM goes to IDLE.
- Reset mid-scan aborts the scan; there is no partial result.
- Capture, per core i:
  - If core_flag[i]=1 and v[i]=0 at an edge, latch the core's val_1/val_2 and set v[i].
  - While v[i]=1, flag and data changes are ignored (first capture wins).
  - Several cores may capture in the same cycle.
- all_done = AND of v[]. It rises the cycle after the last flag is sampled.
- Read port, 1-cycle latency:
  - rd_val_1/rd_val_2/rd_valid are registered from rd_addr each cycle.
  - If rd_addr >= NUM_CORES: both data outputs are 0 and rd_valid=0.
  - An uncaptured core reads data 0 with rd_valid=0.
  - Reading the same core in the cycle it captures returns the old value (0/0).
- clear=1 at an edge:
  - Same effect as reset, except the rd_* registers still update normally from rd_addr.
  - clear takes priority over a simultaneous capture or start_reduce.
  - A flag still high after clear is captured on the next edge.
- Reduce FSM:
  - IDLE: start_reduce=1 with all_done=1 -> SCAN, idx<=0. start_reduce with all_done=0 is ignored.
  - SCAN: one core per cycle. Take entry idx if idx==0 or val_1[idx] < best_val_1 (unsigned strict compare); taking it loads best_val_1, best_val_2 and best_core=idx.
    - Ties keep the lowest index.
    - At idx==NUM_CORES-1, go to DONE; otherwise idx++.
    - start_reduce is ignored during SCAN.
  - DONE: reduce_done=1; results hold. start_reduce=1 (with all_done=1) -> SCAN for a rescan. clear -> IDLE.
- Timing: start_reduce sampled at edge t gives reduce_busy from t+1 through t+NUM_CORES. reduce_done rises at t+NUM_CORES+1.
- Captures cannot change during SCAN (all v=1), so the result is deterministic.
- best_* update during SCAN and are only meaningful when reduce_done=1.

Test Plan:
- Reset and read-back: hold Reset=0 for 2 cycles; read addr 0..31 -> all outputs 0, rd_valid=0, all_done=0, FSM IDLE.
- Staggered capture: raise flags for cores 0..30 one per cycle, with val_1=100+i, val_2=i.
  - all_done rises the cycle after core 30's flag.
  - rd_addr=7 -> rd_val_1=107 and rd_val_2=7 one cycle later.
  - rd_addr=31 -> 0, rd_valid=0.
- Sticky capture: core 3 flags val_1=5. Next cycle its data changes to 9 with the flag still high. rd core 3 -> 5.
- Min search with tie: captures give val_1=50 everywhere except cores 12 and 20 (=7, val_2 12/20). Pulse start_reduce.
  - reduce_busy high for exactly 31 cycles.
  - Then reduce_done=1 with best_val_1=7, best_val_2=12, best_core=12.
- Ignored start: pulse start_reduce with one core not yet flagged -> FSM stays IDLE, reduce_busy never asserts.
- Clear / reset mid-operation: clear during SCAN cycle 10 -> next cycle IDLE, all_done=0, all v cleared. Re-flag all cores -> captures succeed. Repeat with Reset=0 mid-scan -> best_* = 0.
